// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipe: load-use stalls, branch/jump flushes, memory freeze.
// Optional HAZARD_STATS_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int BR_PENALTY = 1,
  parameter int STALL_MAX  = 15,
  parameter int FWD        = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_MemRead,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_dst,
  input  logic       mem_RegWrite,
  input  logic [4:0] mem_dst,
  input  logic       br_taken,
  input  logic       mem_busy,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Bubble,
  output logic       EXMEM_Flush,
  output logic [1:0] pc_sel,
  output logic       hz_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, FREEZE} state_t;

  localparam logic [1:0] FL_LOAD = 2'(BR_PENALTY - 1);
  localparam logic [3:0] ST_LIM  = 4'(STALL_MAX - 1);

  state_t     state, state_nx, saved, saved_nx, cur;
  logic [1:0] fl_cnt, fl_nx;
  logic [3:0] st_cnt, st_nx;
  logic       hz_nx;
  logic       ex_match, mem_match, haz;
  logic       stall_ev, flush_ev;

  assign ex_match  = (ex_dst  != '0) && ((ex_dst  == id_rs) || (id_uses_rt && ex_dst  == id_rt));
  assign mem_match = (mem_dst != '0) && ((mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));

  always_comb begin
    haz = 1'b0;
    if (FWD != 0) haz = ex_MemRead && ex_match;
    else          haz = (ex_RegWrite && ex_match) || (mem_RegWrite && mem_match);
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    EXMEM_Flush = 1'b0;
    pc_sel      = 2'b00;
    state_nx    = state;
    saved_nx    = saved;
    fl_nx       = fl_cnt;
    st_nx       = st_cnt;
    hz_nx       = hz_err;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    // Leaving FREEZE resumes the saved state within this same evaluation.
    cur = (state == FREEZE) ? saved : state;

    if (RESET) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      EXMEM_Flush = 1'b1;
      state_nx    = RUN;
      saved_nx    = RUN;
      fl_nx       = '0;
      st_nx       = '0;
      hz_nx       = 1'b0;
    end else if (mem_busy) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Flush = 1'b1;
      state_nx    = FREEZE;
      saved_nx    = cur;
    end else if (br_taken) begin
      pc_sel      = 2'b10;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      st_nx       = '0;
      flush_ev    = 1'b1;
      if (BR_PENALTY > 1) begin
        state_nx = FLUSH;
        fl_nx    = FL_LOAD;
      end else begin
        state_nx = RUN;
        fl_nx    = '0;
      end
    end else if (cur == FLUSH) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      if (fl_cnt <= 2'd1) begin
        state_nx = RUN;
        fl_nx    = '0;
      end else begin
        state_nx = FLUSH;
        fl_nx    = fl_cnt - 2'd1;
      end
    end else if (haz) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      state_nx    = LDSTALL;
      stall_ev    = 1'b1;
      st_nx       = (st_cnt == 4'hF) ? st_cnt : st_cnt + 4'd1;
      if (st_cnt == ST_LIM) hz_nx = 1'b1;
    end else begin
      state_nx = RUN;
      st_nx    = '0;
      if (id_jump) begin
        pc_sel     = 2'b01;
        IFID_Flush = 1'b1;
        flush_ev   = 1'b1;
      end
    end
  end

  always_ff @(negedge CLK) begin
    state  <= state_nx;
    saved  <= saved_nx;
    fl_cnt <= fl_nx;
    st_cnt <= st_nx;
    hz_err <= hz_nx;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(negedge CLK) begin
    if (RESET) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_ev) stall_cycles <= stall_cycles + 32'd1;
      if (flush_ev) flush_events <= flush_events + 32'd1;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = stall_ev ^ flush_ev;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl: one instance with forwarding/3-edge branch penalty,
// one without forwarding/1-edge penalty, plus directed multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, id_uses_rt, id_jump, ex_MemRead, ex_RegWrite, mem_RegWrite, br_taken, mem_busy;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;

  logic       pcw1, ifw1, iff1, idw1, idb1, emf1, hze1;
  logic       pcw0, ifw0, iff0, idw0, idb0, emf0, hze0;
  logic [1:0] pcs1, pcs0;
  logic [8:0] o1, o0;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, fe1, sc0, fe0;
`endif

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.BR_PENALTY(3), .STALL_MAX(15), .FWD(1)) dut (
    .CLK(CLK), .RESET(RESET), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_dst(ex_dst),
    .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst), .br_taken(br_taken), .mem_busy(mem_busy),
    .PCWrite(pcw1), .IFID_Write(ifw1), .IFID_Flush(iff1), .IDEX_Write(idw1),
    .IDEX_Bubble(idb1), .EXMEM_Flush(emf1), .pc_sel(pcs1), .hz_err(hze1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1), .flush_events(fe1)
`endif
  );

  pipe_hazard_ctrl #(.BR_PENALTY(1), .STALL_MAX(4), .FWD(0)) dut_nf (
    .CLK(CLK), .RESET(RESET), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_dst(ex_dst),
    .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst), .br_taken(br_taken), .mem_busy(mem_busy),
    .PCWrite(pcw0), .IFID_Write(ifw0), .IFID_Flush(iff0), .IDEX_Write(idw0),
    .IDEX_Bubble(idb0), .EXMEM_Flush(emf0), .pc_sel(pcs0), .hz_err(hze0)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc0), .flush_events(fe0)
`endif
  );

  assign o1 = {pcw1, ifw1, iff1, idw1, idb1, emf1, pcs1, hze1};
  assign o0 = {pcw0, ifw0, iff0, idw0, idb0, emf0, pcs0, hze0};

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Flush, pc_sel, hz_err}
  localparam logic [8:0] DEF = 9'b110100000;
  localparam logic [8:0] STL = 9'b000110000;
  localparam logic [8:0] RST = 9'b001111000;
  localparam logic [8:0] BSY = 9'b000001000;
  localparam logic [8:0] BRO = 9'b111110100;
  localparam logic [8:0] FLO = 9'b111110000;
  localparam logic [8:0] JMP = 9'b111100010;

  typedef struct {
    logic rst; logic [4:0] rs; logic [4:0] rt; logic ur; logic jmp;
    logic exmr; logic exrw; logic [4:0] exd; logic mrw; logic [4:0] md; logic br; logic busy;
  } in_t;

  typedef struct { string name; in_t i; logic [8:0] e1; logic [8:0] e0; } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic ur, input logic jmp, input logic exmr, input logic exrw,
                             input logic [4:0] exd, input logic mrw, input logic [4:0] md,
                             input logic br, input logic busy);
    in_t x;
    x.rst = rst; x.rs = rs; x.rt = rt; x.ur = ur; x.jmp = jmp; x.exmr = exmr; x.exrw = exrw;
    x.exd = exd; x.mrw = mrw; x.md = md; x.br = br; x.busy = busy;
    return x;
  endfunction

  function automatic vec_t mkv(input string n, input in_t i, input logic [8:0] e1, input logic [8:0] e0);
    vec_t v;
    v.name = n; v.i = i; v.e1 = e1; v.e0 = e0;
    return v;
  endfunction

  task automatic cyc(input in_t x);
    @(posedge CLK);
    RESET = x.rst; id_rs = x.rs; id_rt = x.rt; id_uses_rt = x.ur; id_jump = x.jmp;
    ex_MemRead = x.exmr; ex_RegWrite = x.exrw; ex_dst = x.exd;
    mem_RegWrite = x.mrw; mem_dst = x.md; br_taken = x.br; mem_busy = x.busy;
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  in_t rsti, nop, lwh, brh, busyh, jmpi, bri, busyj;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rsti  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lwh   = mk(0, 2, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0);
    brh   = mk(0, 2, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0);
    busyh = mk(0, 2, 0, 0, 0, 1, 1, 2, 0, 0, 0, 1);
    jmpi  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    bri   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    busyj = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    RESET = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 1'b0; ex_MemRead = 1'b0;
    ex_RegWrite = 1'b0; ex_dst = '0; mem_RegWrite = 1'b0; mem_dst = '0; br_taken = 1'b0; mem_busy = 1'b0;

    //                       rst rs rt ur j mr rw exd mrw md br busy          fwd1 fwd0
    tbl.push_back(mkv("reset",    mk(1, 2, 0, 0, 1, 1, 1, 2, 0, 0, 1, 0), RST, RST));
    tbl.push_back(mkv("r0_nohaz", mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0), DEF, DEF));
    tbl.push_back(mkv("lw_rs",    mk(0, 2, 9, 0, 0, 1, 1, 2, 0, 0, 0, 0), STL, STL));
    tbl.push_back(mkv("alu_ex",   mk(0, 3, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), DEF, STL));
    tbl.push_back(mkv("mem_rt",   mk(0, 1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0), DEF, STL));
    tbl.push_back(mkv("mem_rt_nu",mk(0, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0), DEF, DEF));
    tbl.push_back(mkv("lw_rt",    mk(0, 1, 7, 1, 0, 1, 1, 7, 0, 0, 0, 0), STL, STL));
    tbl.push_back(mkv("lw_rt_nu", mk(0, 1, 7, 0, 0, 1, 1, 7, 0, 0, 0, 0), DEF, DEF));
    tbl.push_back(mkv("jump",     mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), JMP, JMP));
    tbl.push_back(mkv("jump_haz", mk(0, 4, 0, 0, 1, 1, 1, 4, 0, 0, 0, 0), STL, STL));
    tbl.push_back(mkv("br_haz",   mk(0, 4, 0, 0, 0, 1, 1, 4, 0, 0, 1, 0), BRO, BRO));
    tbl.push_back(mkv("busy_all", mk(0, 4, 0, 0, 1, 1, 1, 4, 0, 0, 1, 1), BSY, BSY));
    tbl.push_back(mkv("br_jump",  mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), BRO, BRO));
    tbl.push_back(mkv("mem_r0",   mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0), DEF, DEF));

    foreach (tbl[k]) begin
      cyc(rsti);
      cyc(tbl[k].i);
      chk({tbl[k].name, "/fwd1"}, 32'(o1), 32'(tbl[k].e1));
      chk({tbl[k].name, "/fwd0"}, 32'(o0), 32'(tbl[k].e0));
    end

    // Single load-use stall then back to normal flow
    cyc(rsti);
    cyc(lwh); chk("lu_stall", 32'(o1), 32'(STL));
    cyc(nop); chk("lu_after", 32'(o1), 32'(DEF));

    // Branch window: 3 edges on dut, 1 on dut_nf; jumps inside the window are wrong-path
    cyc(rsti);
    cyc(bri);  chk("br_res", 32'(o1), 32'(BRO)); chk("br_res_nf", 32'(o0), 32'(BRO));
    cyc(jmpi); chk("br_fl1", 32'(o1), 32'(FLO)); chk("br_jmp_nf", 32'(o0), 32'(JMP));
    cyc(jmpi); chk("br_fl2", 32'(o1), 32'(FLO));
    cyc(jmpi); chk("br_done_jmp", 32'(o1), 32'(JMP));
    cyc(nop);  chk("br_run", 32'(o1), 32'(DEF));

    // Branch on the same edge as a pending load stall
    cyc(rsti);
    cyc(lwh); cyc(lwh);
    cyc(brh); chk("brh_res", 32'(o1), 32'(BRO));
    cyc(lwh); chk("brh_fl1", 32'(o1), 32'(FLO)); chk("brh_stcnt0", 32'(dut.st_cnt), 32'd0);
    cyc(lwh); chk("brh_fl2", 32'(o1), 32'(FLO));
    cyc(lwh); chk("brh_stall", 32'(o1), 32'(STL));
    cyc(nop); chk("brh_stcnt1", 32'(dut.st_cnt), 32'd1);

    // Memory freeze in the middle of a load stall
    cyc(rsti);
    cyc(lwh); cyc(lwh);
    for (int i = 0; i < 4; i++) begin
      cyc(busyh); chk("frz_out", 32'(o1), 32'(BSY)); chk("frz_out_nf", 32'(o0), 32'(BSY));
    end
    chk("frz_stcnt", 32'(dut.st_cnt), 32'd2);
    cyc(lwh); chk("frz_resume", 32'(o1), 32'(STL));
    cyc(nop); chk("frz_stcnt3", 32'(dut.st_cnt), 32'd3); chk("frz_run", 32'(o1), 32'(DEF));

    // Stall watchdog: dut trips after 15 stall edges, dut_nf after 4
    cyc(rsti);
    for (int j = 1; j <= 16; j++) begin
      cyc(lwh);
      chk("wd_fwd1", 32'(o1), 32'(STL | ((j >= 16) ? 9'd1 : 9'd0)));
      chk("wd_fwd0", 32'(o0), 32'(STL | ((j >= 5) ? 9'd1 : 9'd0)));
    end
    cyc(nop);  chk("wd_sticky", 32'(o1), 32'(DEF | 9'd1)); chk("wd_sticky_nf", 32'(o0), 32'(DEF | 9'd1));
    cyc(rsti); chk("wd_reset", 32'(o1), 32'(RST | 9'd1));
    cyc(nop);  chk("wd_clear", 32'(o1), 32'(DEF)); chk("wd_clear_nf", 32'(o0), 32'(DEF));

`ifdef HAZARD_STATS_EN
    cyc(rsti);
    cyc(lwh); cyc(nop); cyc(jmpi); cyc(busyj); cyc(bri); cyc(nop); cyc(nop); cyc(nop);
    chk("stat_stall", sc1, 32'd1); chk("stat_flush", fe1, 32'd2);
    chk("stat_stall_nf", sc0, 32'd1); chk("stat_flush_nf", fe0, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers, plus the next-PC select.
- Detects load-use hazards, sequences the taken-branch flush window, inserts jump flushes, and freezes the whole pipe while memory is busy.
- State updates on the same negedge of CLK as the pipeline registers; control outputs are Mealy, so they take effect at that same edge.

Parameters:
- BR_PENALTY, 1: number of edges with wrong-path kill after a taken branch, counting the resolving edge; legal range 1..3.
- STALL_MAX, 15: consecutive load-stall cycles before hz_err is set; 4-bit counter.
- FWD, 1: 1 means the forwarding unit is present, so only load-use stalls. 0 means any RAW against ID/EX or EX/MEM stalls.

Ports:
- CLK  in  1  pipeline clock; all state updates on negedge.
- RESET  in  1  synchronous, active-high; sampled on negedge CLK.
- id_rs  in  5  rs of the instruction in IF/ID.
- id_rt  in  5  rt of the instruction in IF/ID.
- id_uses_rt  in  1  rt is a source operand (R-type, sw, beq).
- id_jump  in  1  JtoPC decoded in ID.
- ex_MemRead  in  1  ID/EX MemRead.
- ex_RegWrite  in  1  ID/EX RegWrite.
- ex_dst  in  5  ID/EX destination register.
- mem_RegWrite  in  1  EX/MEM RegWrite.
- mem_dst  in  5  EX/MEM destination register.
- br_taken  in  1  branch resolved taken in EX.
- mem_busy  in  1  instruction/data memory not ready.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID clear to nop.
- IDEX_Write  out  1  ID/EX load enable.
- IDEX_Bubble  out  1  zero ID/EX control bits.
- EXMEM_Flush  out  1  zero EX/MEM control bits.
- pc_sel  out  2  00 = PC+4, 01 = jump target, 10 = branch target.
- hz_err  out  1  sticky stall-watchdog error.

Behaviour:
- States: RUN, LDSTALL, FLUSH, FREEZE. Counters: fl_cnt (2 bits), st_cnt (4 bits).
- Hazard definition: haz is true when all of the following hold:
  - (src==rs) or (src==rt && id_uses_rt), where src is a candidate destination below;
  - src != 0; register 0 is never a hazard.
  - FWD=1: the only candidate is ex_dst, and only when ex_MemRead=1.
  - FWD=0: candidates are ex_dst when ex_RegWrite=1, and mem_dst when mem_RegWrite=1.
- Default outputs: PCWrite=1, IFID_Write=1, IDEX_Write=1, all flush/bubble signals 0, pc_sel=00.
- Priority: RESET > mem_busy > br_taken or FLUSH > haz > id_jump.
- RESET=1:
  - Outputs: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, EXMEM_Flush=1, pc_sel=00.
  - Next edge: state=RUN, counters=0, hz_err=0.
  - A reset mid-stall or mid-flush abandons that operation.
- mem_busy=1 (any state):
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Flush=1 (bubble into MEM).
  - State moves to FREEZE; the previous state, fl_cnt and st_cnt are held.
  - br_taken and haz are ignored; the stages are frozen, so these inputs persist and are acted on after release.
  - On mem_busy=0: return to the saved state in the same cycle's evaluation.
- br_taken=1:
  - Outputs: pc_sel=10, IFID_Flush=1, IDEX_Bubble=1.
  - If BR_PENALTY>1: enter FLUSH with fl_cnt=BR_PENALTY-1; otherwise stay in RUN.
  - Overrides haz: the stalled instruction is wrong-path. LDSTALL → FLUSH, st_cnt cleared.
- FLUSH:
  - Outputs: IFID_Flush=1, IDEX_Bubble=1, pc_sel=00.
  - fl_cnt decrements each edge; state returns to RUN at 0.
  - A new br_taken in FLUSH reloads fl_cnt.
- haz (RUN or LDSTALL):
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
  - State=LDSTALL; st_cnt increments, saturating at 15.
  - When st_cnt==STALL_MAX-1 and haz is still present: hz_err←1 (sticky until RESET). Stalling continues.
  - When haz clears: RUN, st_cnt←0.
- id_jump with no higher-priority event: pc_sel=01, IFID_Flush=1 (kills the delay fetch). Single cycle, no state change.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds 32-bit outputs stall_cycles and flush_events, both cleared by RESET and wrapping at 2^32.
  - stall_cycles: +1 per edge where haz causes a stall.
  - flush_events: +1 per br_taken or id_jump acceptance.
  - Neither counter changes while mem_busy=1.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- lw $2 in EX (ex_MemRead=1, ex_dst=2), id_rs=2, FWD=1 → exactly one edge with PCWrite=0, IFID_Write=0, IDEX_Bubble=1, then RUN.
- ex_dst=0, ex_MemRead=1, id_rs=0 → no stall; all defaults.
- br_taken=1 with BR_PENALTY=3 → pc_sel=10 on the resolving edge, then 2 further edges with IFID_Flush=1 and IDEX_Bubble=1, then RUN. Repeat with haz asserted on the same edge → branch wins, st_cnt=0.
- mem_busy=1 for 4 cycles during LDSTALL → all write enables 0 and EXMEM_Flush=1; after release the stall resumes with st_cnt unchanged.
- Hold haz for 16 cycles with STALL_MAX=15 → hz_err rises on the 15th stall edge and stays 1 until RESET; RESET then gives IFID_Flush=1 and state RUN.
- With HAZARD_STATS_EN: 1 load stall + 1 jump + 1 taken branch → stall_cycles=1, flush_events=2.
